// File: rtl/threshold_pkg.sv
// Shared types and arithmetic helpers for the multi-channel threshold filter.
// Optional feature macro used by the top level: THRESH_SLEW_EN.
package threshold_pkg;

    typedef enum logic [1:0] {
        ZERO_BELOW = 2'd0,
        BINARY     = 2'd1,
        HYSTERESIS = 2'd2,
        INVERT     = 2'd3
    } mode_e;

    // Floor(min(bpm, max_bpm) * (2^bits - 1) / max_bpm); the divisor is a
    // constant after elaboration, so synthesis folds it into a multiply.
    function automatic int unsigned bpm_to_threshold(input int unsigned bpm,
                                                     input int bits,
                                                     input int max_bpm);
        longint unsigned clamped;
        longint unsigned full;
        clamped = (bpm > 32'(max_bpm)) ? 64'(max_bpm) : 64'(bpm);
        full    = (64'd1 << bits) - 64'd1;
        return 32'((clamped * full) / 64'(max_bpm));
    endfunction

    // a + b clipped to the largest code representable in 'bits' bits.
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int bits);
        longint unsigned sum;
        longint unsigned max_v;
        sum   = 64'(a) + 64'(b);
        max_v = (64'd1 << bits) - 64'd1;
        return 32'((sum > max_v) ? max_v : sum);
    endfunction

    // a - b clipped at zero.
    function automatic int unsigned sat_sub(input int unsigned a,
                                            input int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // Move cur toward tgt by no more than step; lands on tgt when close enough.
    function automatic int unsigned slew_toward(input int unsigned cur,
                                                input int unsigned tgt,
                                                input int unsigned step);
        if (tgt > cur) begin
            return ((tgt - cur) > step) ? (cur + step) : tgt;
        end
        return ((cur - tgt) > step) ? (cur - step) : tgt;
    endfunction

endpackage

// File: rtl/threshold_channel.sv
// One colour channel: mode-dependent compare plus the hysteresis state bit.
// The caller supplies the threshold/mode/enable already in effect for the
// current beat, so a start-of-frame beat is filtered with the new settings.
module threshold_channel
    import threshold_pkg::*;
#(
    parameter int BITS = 8,
    parameter int HYST = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] pix,
    input  logic [BITS-1:0] thr,
    input  mode_e           mode,
    input  logic            en,
    input  logic            update,
    input  logic            clear,
    output logic [BITS-1:0] pix_filt
);

    logic [BITS-1:0] hi;
    logic [BITS-1:0] lo;
    logic            hyst_now;
    logic            hyst_d;
    logic            hyst_q;

    // Hysteresis band edges and the bit value after applying this beat.
    always_comb begin
        hi       = BITS'(sat_add(32'(thr), HYST, BITS));
        lo       = BITS'(sat_sub(32'(thr), HYST));
        hyst_now = clear ? 1'b0 : hyst_q;
        if (pix > hi) begin
            hyst_now = 1'b1;
        end else if (pix < lo) begin
            hyst_now = 1'b0;
        end
        hyst_d = update ? hyst_now : hyst_q;
    end

    // Hysteresis state advances only on accepted beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hyst_q <= 1'b0;
        end else begin
            hyst_q <= hyst_d;
        end
    end

    // Per-mode output selection; disabled filter passes the pixel through.
    always_comb begin
        pix_filt = pix;
        if (en) begin
            case (mode)
                ZERO_BELOW: pix_filt = (pix > thr) ? pix : '0;
                BINARY:     pix_filt = (pix > thr) ? '1  : '0;
                HYSTERESIS: pix_filt = hyst_now    ? pix : '0;
                INVERT:     pix_filt = (pix <= thr) ? pix : '0;
                default:    pix_filt = pix;
            endcase
        end
    end

endmodule

// File: rtl/threshold_filter_mc.sv
// Multi-channel brightness threshold filter with frame-coherent settings and
// a one-entry skid buffer for full-rate valid/ready flow.
// Optional feature macro: THRESH_SLEW_EN (limit threshold change per frame).
module threshold_filter_mc
    import threshold_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int CHANNELS  = 3,
    parameter int MAX_BPM   = 200,
    parameter int HYST      = 8,
    parameter int SLEW_STEP = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*BITS-1:0]     pix_in,
    input  logic                         sof_in,
    input  logic                         valid_in,
    output logic                         output_ready,
    input  logic                         module_ready,
    input  logic                         filter_enable,
    input  logic [1:0]                   mode,
    input  logic [$clog2(MAX_BPM+1)-1:0] BPM_estimate,
    output logic [CHANNELS*BITS-1:0]     pix_out,
    output logic                         sof_out,
    output logic                         valid_out,
    output logic [BITS-1:0]              brightness
);

    localparam int W = CHANNELS * BITS;
`ifdef THRESH_SLEW_EN
    localparam int unsigned STEP_EFF = SLEW_STEP;
`else
    // A step wider than the code range always reaches the target in one go;
    // SLEW_STEP is intentionally ignored in this build.
    localparam int unsigned STEP_EFF = (SLEW_STEP >= 0) ? (1 << BITS) : (1 << BITS);
`endif

    logic            accept;
    logic            frame_start;
    logic            out_xfer;
    logic [BITS-1:0] tgt;
    logic [W-1:0]    filt_pix;

    logic [BITS-1:0] thr_d, thr_q;
    mode_e           mode_d, mode_q;
    logic            en_d, en_q;
    logic            out_valid_d, out_valid_q;
    logic [W-1:0]    out_pix_d, out_pix_q;
    logic            out_sof_d, out_sof_q;
    logic            skid_valid_d, skid_valid_q;
    logic [W-1:0]    skid_pix_d, skid_pix_q;
    logic            skid_sof_d, skid_sof_q;
    logic            ready_d, ready_q;

    assign tgt = BITS'(bpm_to_threshold(32'(BPM_estimate), BITS, MAX_BPM));

    // Frame latch: settings captured on an accepted sof beat, held otherwise.
    always_comb begin
        accept      = valid_in && ready_q;
        frame_start = accept && sof_in;
        thr_d       = thr_q;
        mode_d      = mode_q;
        en_d        = en_q;
        if (frame_start) begin
            thr_d  = BITS'(slew_toward(32'(thr_q), 32'(tgt), STEP_EFF));
            mode_d = mode_e'(mode);
            en_d   = filter_enable;
        end
    end

    // The *_d settings are the ones governing the beat being accepted now.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        threshold_channel #(
            .BITS (BITS),
            .HYST (HYST)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .pix      (pix_in[gi*BITS +: BITS]),
            .thr      (thr_d),
            .mode     (mode_d),
            .en       (en_d),
            .update   (accept),
            .clear    (frame_start),
            .pix_filt (filt_pix[gi*BITS +: BITS])
        );
    end

    // Output register and skid entry: skid refills the output first, so
    // beat order is preserved; ready is a registered copy of skid emptiness.
    always_comb begin
        out_xfer     = out_valid_q && module_ready;
        out_valid_d  = out_valid_q;
        out_pix_d    = out_pix_q;
        out_sof_d    = out_sof_q;
        skid_valid_d = skid_valid_q;
        skid_pix_d   = skid_pix_q;
        skid_sof_d   = skid_sof_q;
        if (out_xfer || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pix_d    = skid_pix_q;
                out_sof_d    = skid_sof_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_pix_d   = filt_pix;
                out_sof_d   = sof_in;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pix_d   = filt_pix;
            skid_sof_d   = sof_in;
        end
        ready_d = !skid_valid_d;
    end

    // State registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_q        <= '0;
            mode_q       <= ZERO_BELOW;
            en_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pix_q    <= '0;
            out_sof_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pix_q   <= '0;
            skid_sof_q   <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            thr_q        <= thr_d;
            mode_q       <= mode_d;
            en_q         <= en_d;
            out_valid_q  <= out_valid_d;
            out_pix_q    <= out_pix_d;
            out_sof_q    <= out_sof_d;
            skid_valid_q <= skid_valid_d;
            skid_pix_q   <= skid_pix_d;
            skid_sof_q   <= skid_sof_d;
            ready_q      <= ready_d;
        end
    end

    assign output_ready = ready_q;
    assign pix_out      = out_pix_q;
    assign sof_out      = out_sof_q;
    assign valid_out    = out_valid_q;
    assign brightness   = thr_q;

endmodule

// File: tb/tb_threshold_filter_mc.sv
// Self-checking bench for threshold_filter_mc (default parameters).
module tb_threshold_filter_mc;

    localparam int BITS    = 8;
    localparam int CH      = 3;
    localparam int MAX_BPM = 200;
    localparam int HYST    = 8;
    localparam int SLEW    = 16;
    localparam int W       = CH * BITS;
    localparam int BW      = $clog2(MAX_BPM + 1);
    localparam int FULL    = (1 << BITS) - 1;

    typedef struct {
        logic [W-1:0] pix;
        logic         sof;
        int           cyc;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    pix_in;
    logic            sof_in;
    logic            valid_in;
    logic            output_ready;
    logic            module_ready;
    logic            filter_enable;
    logic [1:0]      mode;
    logic [BW-1:0]   bpm;
    logic [W-1:0]    pix_out;
    logic            sof_out;
    logic            valid_out;
    logic [BITS-1:0] brightness;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    acc_flag;
    beat_t obs_q[$];
    beat_t exp_q[$];

    // Reference model state: what the filter should currently be applying.
    int m_thr;
    int m_mode;
    int m_en;
    bit m_hyst[CH];

    threshold_filter_mc #(
        .BITS(BITS), .CHANNELS(CH), .MAX_BPM(MAX_BPM), .HYST(HYST), .SLEW_STEP(SLEW)
    ) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .sof_in(sof_in),
        .valid_in(valid_in), .output_ready(output_ready), .module_ready(module_ready),
        .filter_enable(filter_enable), .mode(mode), .BPM_estimate(bpm),
        .pix_out(pix_out), .sof_out(sof_out), .valid_out(valid_out),
        .brightness(brightness)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_thr = 0; m_mode = 0; m_en = 0;
        for (int c = 0; c < CH; c++) m_hyst[c] = 1'b0;
    endtask

    // Behavioural model of one accepted beat, straight from the filter rules.
    task automatic model_accept();
        beat_t e;
        int p, o, hi, lo, tgt, b;
        if (sof_in) begin
            b   = (int'(bpm) > MAX_BPM) ? MAX_BPM : int'(bpm);
            tgt = (b * FULL) / MAX_BPM;
`ifdef THRESH_SLEW_EN
            if (tgt > m_thr + SLEW) tgt = m_thr + SLEW;
            else if (tgt < m_thr - SLEW) tgt = m_thr - SLEW;
`endif
            m_thr = tgt; m_mode = int'(mode); m_en = int'(filter_enable);
            for (int c = 0; c < CH; c++) m_hyst[c] = 1'b0;
        end
        for (int c = 0; c < CH; c++) begin
            p = int'(pix_in[c*BITS +: BITS]);
            o = p;
            if (m_en != 0) begin
                case (m_mode)
                    0: o = (p > m_thr) ? p : 0;
                    1: o = (p > m_thr) ? FULL : 0;
                    2: begin
                        hi = (m_thr + HYST > FULL) ? FULL : m_thr + HYST;
                        lo = (m_thr - HYST < 0) ? 0 : m_thr - HYST;
                        if (p > hi) m_hyst[c] = 1'b1;
                        else if (p < lo) m_hyst[c] = 1'b0;
                        o = m_hyst[c] ? p : 0;
                    end
                    default: o = (p <= m_thr) ? p : 0;
                endcase
            end
            e.pix[c*BITS +: BITS] = BITS'(o);
        end
        e.sof = sof_in;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // One clock: record transfers due at the coming edge, advance to next negedge.
    task automatic tick();
        beat_t o;
        acc_flag = 1'b0;
        if (valid_out && module_ready) begin
            o.pix = pix_out; o.sof = sof_out; o.cyc = cyc;
            obs_q.push_back(o);
        end
        if (valid_in && output_ready) begin
            model_accept();
            acc_flag = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        valid_in = 1'b0; sof_in = 1'b0; module_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; valid_in = 1'b0; sof_in = 1'b0; pix_in = '0;
        module_ready = 1'b1; filter_enable = 1'b0; mode = 2'd0; bpm = '0;
        model_reset();
        #2;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (sof_out !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", sof_out); end
        checks++; if (pix_out !== '0) begin errors++; $display("FAIL reset_pix: got %h want 0", pix_out); end
        checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", output_ready); end
        checks++; if (brightness !== '0) begin errors++; $display("FAIL reset_brightness: got %0d want 0", brightness); end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (output_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", output_ready); end
        $display("test_reset done");
    endtask

`ifdef THRESH_SLEW_EN
    task automatic test_slew();
        int want;
        filter_enable = 1'b0; mode = 2'd0; module_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            bpm = (k == 0) ? BW'(0) : BW'(MAX_BPM);
            valid_in = 1'b1; sof_in = 1'b1; pix_in = W'($urandom);
            tick();
            want = (k * SLEW > FULL) ? FULL : k * SLEW;
            checks++; if (brightness !== BITS'(want)) begin errors++; $display("FAIL slew_frame%0d: got %0d want %0d", k, brightness, want); end
            $display("slew frame %0d brightness %0d", k, brightness);
        end
        drain();
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_transparent();
        int vals[3] = '{0, 127, 255};
        logic [W-1:0] want;
        filter_enable = 1'b0; mode = 2'd1; bpm = BW'(100); module_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; sof_in = (i == 0); pix_in = {CH{BITS'(vals[i])}};
            tick();
        end
        drain();
        checks++; if (obs_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL transparent_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size() && i < exp_q.size(); i++) begin
            want = {CH{BITS'(vals[i])}};
            checks++; if (obs_q[i].pix !== want || obs_q[i].sof !== (i == 0)) begin errors++; $display("FAIL transparent_pix%0d: got %h want %h", i, obs_q[i].pix, want); end
            checks++; if (obs_q[i].cyc - exp_q[i].cyc != 1) begin errors++; $display("FAIL transparent_latency%0d: got %0d want 1", i, obs_q[i].cyc - exp_q[i].cyc); end
            checks++; if (obs_q[i].cyc != obs_q[0].cyc + i) begin errors++; $display("FAIL transparent_contig%0d: got cycle %0d want %0d", i, obs_q[i].cyc, obs_q[0].cyc + i); end
            $display("transparent beat %0d out %h", i, obs_q[i].pix);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_zero_below();
        filter_enable = 1'b1; mode = 2'd0; bpm = BW'(100); module_ready = 1'b1;
        valid_in = 1'b1; sof_in = 1'b1; pix_in = {8'd128, 8'd127, 8'd126};
        tick();
        checks++; if (brightness !== BITS'(m_thr)) begin errors++; $display("FAIL zb_brightness_model: got %0d want %0d", brightness, m_thr); end
`ifndef THRESH_SLEW_EN
        checks++; if (brightness !== 8'd127) begin errors++; $display("FAIL zb_brightness: got %0d want 127", brightness); end
`endif
        bpm = BW'(250); sof_in = 1'b1; pix_in = W'($urandom);
        tick();
`ifndef THRESH_SLEW_EN
        checks++; if (brightness !== 8'd255) begin errors++; $display("FAIL zb_clamp_brightness: got %0d want 255", brightness); end
`endif
        sof_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_in = W'($urandom); pix_in[BITS-1:0] = '1;
            tick();
        end
        drain();
        checks++; if (obs_q.size() != 5 || exp_q.size() != 5) begin errors++; $display("FAIL zb_count: got %0d want 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i].pix !== exp_q[i].pix) begin errors++; $display("FAIL zb_model%0d: got %h want %h", i, obs_q[i].pix, exp_q[i].pix); end
`ifndef THRESH_SLEW_EN
            checks++; if (obs_q[i].pix !== ((i == 0) ? W'(24'h800000) : W'(0))) begin errors++; $display("FAIL zb_pix%0d: got %h want %h", i, obs_q[i].pix, (i == 0) ? W'(24'h800000) : W'(0)); end
`endif
            $display("zero_below beat %0d out %h", i, obs_q[i].pix);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_binary_invert();
        int vals[6]  = '{31, 32, 31, 32, 31, 32};
        int sofs[6]  = '{1, 0, 0, 0, 1, 0};
        int modes[6] = '{1, 1, 3, 3, 3, 3};
        int want[6]  = '{0, 255, 0, 255, 31, 0};
        filter_enable = 1'b1; bpm = BW'(25); module_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1; sof_in = (sofs[i] != 0); mode = 2'(modes[i]);
            pix_in = {CH{BITS'(vals[i])}};
            tick();
`ifndef THRESH_SLEW_EN
            if (i == 0) begin
                checks++; if (brightness !== 8'd31) begin errors++; $display("FAIL bin_brightness: got %0d want 31", brightness); end
            end
`endif
        end
        drain();
        checks++; if (obs_q.size() != 6 || exp_q.size() != 6) begin errors++; $display("FAIL bin_count: got %0d want 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i].pix !== exp_q[i].pix) begin errors++; $display("FAIL bin_model%0d: got %h want %h", i, obs_q[i].pix, exp_q[i].pix); end
`ifndef THRESH_SLEW_EN
            checks++; if (obs_q[i].pix !== {CH{BITS'(want[i])}}) begin errors++; $display("FAIL bin_pix%0d: got %h want %h", i, obs_q[i].pix, {CH{BITS'(want[i])}}); end
`endif
            $display("binary/invert beat %0d out %h", i, obs_q[i].pix);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_hysteresis();
        int vals[8] = '{130, 136, 130, 118, 119, 125, 136, 130};
        int sofs[8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        int want[8] = '{0, 136, 130, 0, 0, 0, 136, 0};
        filter_enable = 1'b1; mode = 2'd2; bpm = BW'(100); module_ready = 1'b1;
`ifdef THRESH_SLEW_EN
        sof_in = 1'b1; valid_in = 1'b1; pix_in = '0;
        for (int k = 0; k < 20 && m_thr != 127; k++) tick();
`endif
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1; sof_in = (sofs[i] != 0); pix_in = {CH{BITS'(vals[i])}};
            tick();
        end
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hyst_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i].pix !== exp_q[i].pix) begin errors++; $display("FAIL hyst_model%0d: got %h want %h", i, obs_q[i].pix, exp_q[i].pix); end
        end
        for (int i = 0; i < 8; i++) begin
            int j = obs_q.size() - 8 + i;
            if (j >= 0) begin
                checks++; if (obs_q[j].pix !== {CH{BITS'(want[i])}}) begin errors++; $display("FAIL hyst_pix%0d: got %h want %h", i, obs_q[j].pix, {CH{BITS'(want[i])}}); end
                $display("hysteresis beat %0d in %0d out %h", i, vals[i], obs_q[j].pix);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        filter_enable = 1'b0; mode = 2'd0; bpm = BW'(100);
        for (int k = 0; k < 40 && idx < 6; k++) begin
            module_ready = !(k >= 1 && k <= 3);
            valid_in = 1'b1; sof_in = (idx == 0); pix_in = {CH{BITS'(idx + 1)}};
            if (k == 1) begin
                checks++; if (output_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first_stall: got %b want 1", output_ready); end
            end
            if (k == 2 || k == 3) begin
                checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall%0d: got %b want 0", k, output_ready); end
                checks++; if (valid_out !== 1'b1 || pix_out !== {CH{8'd1}}) begin errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/%h", k, valid_out, pix_out, {CH{8'd1}}); end
            end
            tick();
            if (acc_flag) idx++;
        end
        checks++; if (idx != 6) begin errors++; $display("FAIL bp_accept_timeout: got %0d want 6", idx); end
        drain();
        checks++; if (obs_q.size() != 6 || exp_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 6; i++) begin
            checks++; if (obs_q[i].pix !== {CH{BITS'(i + 1)}}) begin errors++; $display("FAIL bp_order%0d: got %h want %h", i, obs_q[i].pix, {CH{BITS'(i + 1)}}); end
            $display("backpressure beat %0d out %h", i, obs_q[i].pix);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int sent = 0;
        beat_t o, e;
        for (int k = 0; k < 20000 && sent < 1000; k++) begin
            valid_in      = ($urandom_range(0, 9) < 7);
            sof_in        = ($urandom_range(0, 39) == 0);
            pix_in        = W'($urandom);
            module_ready  = ($urandom_range(0, 9) < 7);
            filter_enable = ($urandom_range(0, 3) != 0);
            mode          = 2'($urandom_range(0, 3));
            bpm           = BW'($urandom_range(0, (1 << BW) - 1));
            tick();
            if (acc_flag) sent++;
            checks++; if (brightness !== BITS'(m_thr)) begin errors++; $display("FAIL rnd_brightness@%0d: got %0d want %0d", cyc, brightness, m_thr); end
        end
        checks++; if (sent != 1000) begin errors++; $display("FAIL rnd_accept_timeout: got %0d want 1000", sent); end
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o.pix !== e.pix || o.sof !== e.sof) begin errors++; $display("FAIL rnd_beat%0d: got %h/%b want %h/%b", i, o.pix, o.sof, e.pix, e.sof); end
            $display("random beat %0d out %h sof %b", i, o.pix, o.sof);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_stall();
        filter_enable = 1'b1; mode = 2'd0; bpm = BW'(150); module_ready = 1'b0;
        valid_in = 1'b1; sof_in = 1'b1; pix_in = W'($urandom);
        repeat (3) begin tick(); sof_in = 1'b0; end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b want 1", valid_out); end
        #2 reset = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_drop: got %b want 0", valid_out); end
        checks++; if (brightness !== '0) begin errors++; $display("FAIL rst_brightness: got %0d want 0", brightness); end
        checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", output_ready); end
        @(negedge clk);
        reset = 1'b1; valid_in = 1'b0; module_ready = 1'b1;
        model_reset(); obs_q.delete(); exp_q.delete();
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_post_valid: got %b want 0", valid_out); end
        checks++; if (output_ready !== 1'b1) begin errors++; $display("FAIL rst_post_ready: got %b want 1", output_ready); end
        $display("reset mid-stall done");
    endtask

    initial begin
        test_reset();
`ifdef THRESH_SLEW_EN
        test_slew();
`endif
        test_transparent();
        test_zero_below();
        test_binary_invert();
        test_hysteresis();
        test_back_to_back();
        test_random();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
